// File: rtl/stream_row_packer_if.sv
// stream_row_packer_if: element beat stream in, packed row stream out.
// The slave modport is the packer's view; the master modport is its surroundings.
interface stream_row_packer_if #(
    parameter int BUS_WIDTH = 32,
    parameter int ROW_W     = 24
);
    logic [BUS_WIDTH-1:0] s_axis_tdata;
    logic                 s_axis_tvalid;
    logic                 s_axis_tready;
    logic                 s_axis_tlast;
    logic [ROW_W-1:0]     m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic                 m_axis_tlast;
    logic                 m_axis_tuser;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/stream_row_packer.sv
// stream_row_packer: packs narrow element beats into ROW_ELEMS-wide rows
// through a two-slot ping-pong buffer, with tlast-closed zero-padded short rows.
module stream_row_packer #(
    parameter int ELEM_WIDTH = 8,
    parameter int ROW_ELEMS  = 3,
    parameter int BUS_WIDTH  = 32,
    parameter bit MSB_FIRST  = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                enable,
    stream_row_packer_if.slave  bus,
    output logic [31:0]         rows_emitted,
    output logic [15:0]         short_rows
);
    localparam int EPB   = BUS_WIDTH / ELEM_WIDTH;
    localparam int NT    = (ROW_ELEMS + EPB - 1) / EPB;
    localparam int ROW_W = ROW_ELEMS * ELEM_WIDTH;
    localparam int TW    = NT > 1 ? $clog2(NT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(NT - 1);

    logic [ROW_W-1:0] acc, row_next;
    logic [ROW_W-1:0] slot_data [2];
    logic [1:0]       full, slot_last, slot_user;
    logic             wp, rp, push, pop, close, unused_bits;
    logic [TW-1:0]    t;

    // When both slots are full, wp == rp, so a same-cycle pop frees the slot being written
    assign pop                = full[rp] & bus.m_axis_tready;
    assign bus.s_axis_tready  = enable & (~full[wp] | pop);
    assign push               = bus.s_axis_tvalid & bus.s_axis_tready;
    assign close              = (t == T_LAST) | bus.s_axis_tlast;
    assign bus.m_axis_tvalid  = full[rp];
    assign bus.m_axis_tdata   = slot_data[rp];
    assign bus.m_axis_tlast   = slot_last[rp];
    assign bus.m_axis_tuser   = slot_user[rp];
    assign unused_bits        = ^bus.s_axis_tdata;

    // Row element k arrives on beat k/EPB in lane k%EPB; later elements read as zero until written
    for (genvar k = 0; k < ROW_ELEMS; k++) begin : g_elem
        localparam int RB = MSB_FIRST ? ROW_W - ELEM_WIDTH * (k + 1) : ELEM_WIDTH * k;
        localparam int BB = MSB_FIRST ? BUS_WIDTH - ELEM_WIDTH * (k % EPB + 1) : ELEM_WIDTH * (k % EPB);
        assign row_next[RB +: ELEM_WIDTH] = t == TW'(k / EPB) ? bus.s_axis_tdata[BB +: ELEM_WIDTH]
                                          : t == '0 ? '0 : acc[RB +: ELEM_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rstn || !enable) begin
            full         <= '0;
            slot_last    <= '0;
            slot_user    <= '0;
            slot_data[0] <= '0;
            slot_data[1] <= '0;
            acc          <= '0;
            t            <= '0;
            wp           <= 1'b0;
            rp           <= 1'b0;
        end else begin
            if (pop) begin
                full[rp]      <= 1'b0;
                slot_last[rp] <= 1'b0;
                slot_user[rp] <= 1'b0;
                slot_data[rp] <= '0;
                rp            <= ~rp;
            end
            if (push && close) begin
                full[wp]      <= 1'b1;
                slot_data[wp] <= row_next;
                slot_last[wp] <= bus.s_axis_tlast;
                slot_user[wp] <= t != T_LAST;
                wp            <= ~wp;
                t             <= '0;
            end else if (push) begin
                acc <= row_next;
                t   <= t + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rows_emitted <= '0;
            short_rows   <= '0;
        end else if (enable && pop) begin
            rows_emitted <= rows_emitted + 32'd1;
            short_rows   <= short_rows + 16'(slot_user[rp] && !(&short_rows));
        end
    end
endmodule

// File: doc/stream_row_packer.md
Name: stream_row_packer

Overview:
- Packs a narrow AXI-Stream of pixel/kernel elements into complete rows of ROW_ELEMS elements for the map-inflation convolution datapath.
- Generalises the single-buffer row accumulator in four ways: configurable element and bus widths, selectable lane order, tlast-terminated short rows, and a two-slot ping-pong buffer so input can be accepted while an output row is held.
- Sits between the DMA/weight-stream front end and the kernel window / MAC array.

Parameters:
- ELEM_WIDTH, 8, bits per element.
- ROW_ELEMS, 3, elements per output row (kernel size).
- BUS_WIDTH, 32, input bus width. Must be a multiple of ELEM_WIDTH.
- MSB_FIRST, 1. If 1, element 0 is in the MSBs of both the bus word and the output row. If 0, element 0 is in the LSBs of both.
- Derived: EPB = BUS_WIDTH/ELEM_WIDTH; NT = ceil(ROW_ELEMS/EPB); ROW_W = ROW_ELEMS*ELEM_WIDTH.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- enable  in  1  low = flush; held low during weight loading
- s_axis_tdata  in  BUS_WIDTH  input element word
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  end of input line
- m_axis_tdata  out  ROW_W  packed row
- m_axis_tvalid  out  1  row valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  row closed by input tlast
- m_axis_tuser  out  1  short row (zero-padded)
- rows_emitted  out  32  count of rows handed off (m valid & ready)
- short_rows  out  16  count of short rows handed off, saturating at 0xFFFF

Behaviour:
- Decided: reset is rstn, synchronous, active-low; clock is clk. All registers update on the posedge of clk.
- Reset values: all slots empty; m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, rows_emitted=0, short_rows=0. The transfer counter and write/read pointers reset to 0.
- enable=0 while rstn=1: same clearing as reset, except rows_emitted and short_rows hold their values. s_axis_tready=0 while enable=0.
- Storage: two row slots, each ROW_W data plus tlast and tuser flags. Write pointer wp, read pointer rp, occupancy 0..2.
- s_axis_tready = enable & (occupancy<2), or enable & (occupancy==2 & m_axis_tvalid & m_axis_tready). The same-cycle pop frees a slot.
- Per accepted beat at transfer index t (0..NT-1), element e of the word (e=0 is first per MSB_FIRST) writes row element t*EPB+e when that index is below ROW_ELEMS. Elements at index ROW_ELEMS or above are discarded.
- Row close condition: t==NT-1 or s_axis_tlast=1.
- On close: the slot is marked full with tlast=s_axis_tlast and tuser=(t<NT-1). Unwritten elements of a short row are zero. t returns to 0 and wp toggles.
- tlast on beat NT-1 gives a normal row with tlast=1 and tuser=0.
- Without tlast, rows close every NT beats and tlast=0.
- Latency: m_axis_tvalid rises the cycle after the closing beat is accepted (registered output). An empty-to-full-to-pop path takes at least 1 cycle.
- Output: m_axis_tvalid = slot[rp] full. tdata, tlast and tuser come from slot[rp] and stay stable while valid & !ready.
- On m valid & ready: the slot is cleared, rp toggles, rows_emitted increments, and short_rows increments (saturating) if tuser=1.
- Simultaneous push-close and pop in the same cycle: both take effect and occupancy is unchanged.
- Back-to-back operation: with m_axis_tready held at 1, sustained throughput is 1 beat per cycle and 1 row per NT cycles.
- rows_emitted wraps modulo 2^32.
- Partial row in progress when enable drops: the row is discarded and no output is produced.

Test Plan:
- Defaults, beats 0xAABBCCDD, 0x11223344, m_ready=1 -> rows 0xAABBCC then 0x112233, tuser=0, rows_emitted=2.
- ELEM_WIDTH=8, ROW_ELEMS=6, BUS_WIDTH=32, MSB_FIRST=0, beats 0x04030201, 0x0A090605 -> m_axis_tdata=0x060504030201.
- ROW_ELEMS=6, tlast on first beat 0x04030201, MSB_FIRST=0 -> tdata=0x000004030201, tuser=1, tlast=1, short_rows=1.
- m_ready=0, stream 3 rows -> 2 rows buffered, s_axis_tready=0 after the 2nd close; raise m_ready -> rows emerge in order with data stable while stalled, and the 3rd row is accepted.
- Reset and enable: enable dropped mid-row (ROW_ELEMS=6, after 1 beat) -> no output and counters unchanged; rstn=0 -> all outputs and counters read 0 the next cycle.
